// File: rtl/pwm_fade_seq.sv
// pwm_fade_seq: four-channel triangle ("breathing") duty sequencer.
// Channels start a quarter period apart. The pattern advances only on PWM
// period boundaries, after STEP_DIV ticks have been seen. All outputs are
// taken straight from flops.
module pwm_fade_seq #(
   parameter int PERIOD   = 100,
   parameter int DUTY_W   = 8,
   parameter int STEP     = 1,
   parameter int STEP_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  en_in,
   input  logic                  sync_in,
   input  logic                  period_tick_in,
   output logic [4*DUTY_W-1:0]   duty_out,
   output logic [3:0]            dir_out,
   output logic                  update_out
);

   localparam int              PS_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int              XW       = DUTY_W + 1;
   localparam logic [PS_W-1:0] PS_LAST  = PS_W'(STEP_DIV - 1);
   localparam logic [XW-1:0]   PERIOD_X = XW'(PERIOD);
   localparam logic [XW-1:0]   STEP_X   = XW'(STEP);

   // Starting duty of a channel: a quarter period per channel index.
   function automatic logic [DUTY_W-1:0] init_duty(input int ch);
      return DUTY_W'((ch * PERIOD) / 4);
   endfunction

   // Next duty after one step. One extra bit of headroom so the
   // comparisons never wrap; endpoints clamp to PERIOD and 0.
   function automatic logic [DUTY_W-1:0] step_duty(input logic [DUTY_W-1:0] duty,
                                                   input logic              up);
      logic [XW-1:0] wide;
      wide = {1'b0, duty};
      if (up)
         step_duty = (wide + STEP_X >= PERIOD_X) ? PERIOD_X[DUTY_W-1:0]
                                                 : DUTY_W'(wide + STEP_X);
      else
         step_duty = (wide <= STEP_X) ? '0 : DUTY_W'(wide - STEP_X);
   endfunction

   // Next direction after one step: flips only on the step that reaches an
   // endpoint, so each endpoint is held for exactly one step.
   function automatic logic step_dir(input logic [DUTY_W-1:0] duty,
                                     input logic              up);
      logic [XW-1:0] wide;
      wide = {1'b0, duty};
      if (up)
         step_dir = !(wide + STEP_X >= PERIOD_X);
      else
         step_dir = (wide <= STEP_X);
   endfunction

   logic [DUTY_W-1:0] duty_q [4];
   logic [DUTY_W-1:0] duty_d [4];
   logic [3:0]        dir_q, dir_d;
   logic [PS_W-1:0]   ps_q, ps_d;
   logic              upd_q, upd_d;

   // Next state: sync wins over a step; disabling clears the prescaler and
   // freezes the pattern.
   always_comb begin
      ps_d  = ps_q;
      dir_d = dir_q;
      upd_d = 1'b0;
      for (int i = 0; i < 4; i++) duty_d[i] = duty_q[i];
      if (sync_in) begin
         for (int i = 0; i < 4; i++) duty_d[i] = init_duty(i);
         dir_d = '1;
         ps_d  = '0;
         upd_d = 1'b1;
      end else if (!en_in) begin
         ps_d = '0;
      end else if (period_tick_in) begin
         if (ps_q == PS_LAST) begin
            ps_d  = '0;
            upd_d = 1'b1;
            for (int i = 0; i < 4; i++) begin
               duty_d[i] = step_duty(duty_q[i], dir_q[i]);
               dir_d[i]  = step_dir(duty_q[i], dir_q[i]);
            end
         end else begin
            ps_d = ps_q + 1'b1;
         end
      end
   end

   // State registers; reset loads the starting pattern immediately.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < 4; i++) duty_q[i] <= init_duty(i);
         dir_q <= '1;
         ps_q  <= '0;
         upd_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) duty_q[i] <= duty_d[i];
         dir_q <= dir_d;
         ps_q  <= ps_d;
         upd_q <= upd_d;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_pack
      assign duty_out[g*DUTY_W +: DUTY_W] = duty_q[g];
   end

   assign dir_out    = dir_q;
   assign update_out = upd_q;

endmodule

// File: tb/tb_pwm_fade_seq.sv
// Bench for pwm_fade_seq: a default instance checked every cycle against a
// closed-form triangle model, plus a STEP=30/STEP_DIV=1 instance checked
// against hand-computed turnaround tables.
module tb_pwm_fade_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        en_a = 1'b0, sync_a = 1'b0, tick_a = 1'b0;
   logic        sync_b = 1'b0, tick_b = 1'b0;
   logic [31:0] duty_a, duty_b;
   logic [3:0]  dir_a, dir_b;
   logic        upd_a, upd_b;

   int errs = 0;
   int checks = 0;

   pwm_fade_seq #(.PERIOD(100), .DUTY_W(8), .STEP(1), .STEP_DIV(4)) u_a (
      .clk(clk), .rst_in(rst), .en_in(en_a), .sync_in(sync_a),
      .period_tick_in(tick_a), .duty_out(duty_a), .dir_out(dir_a),
      .update_out(upd_a));

   pwm_fade_seq #(.PERIOD(100), .DUTY_W(8), .STEP(30), .STEP_DIV(1)) u_b (
      .clk(clk), .rst_in(rst), .en_in(1'b1), .sync_in(sync_b),
      .period_tick_in(tick_b), .duty_out(duty_b), .dir_out(dir_b),
      .update_out(upd_b));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int chan(input logic [31:0] v, input int i);
      return int'((v >> (8 * i)) & 32'hFF);
   endfunction

   // Triangle position of channel i after k steps of size 1: unfold the
   // triangle onto a 200-step circle starting at i*25, then fold it back.
   function automatic int exp_duty(input int i, input int k);
      int u;
      u = (25 * i + k) % 200;
      return (u <= 100) ? u : 200 - u;
   endfunction

   function automatic int exp_dir(input int i, input int k);
      int u;
      u = (25 * i + k) % 200;
      return (u < 100) ? 1 : 0;
   endfunction

   // Model: number of steps since the last reset/sync, tick prescaler, pulse.
   int m_k = 0, m_pre = 0, m_upd = 0;
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_k = 0; m_pre = 0; m_upd = 0;
      end else begin
         m_upd = 0;
         if (sync_a) begin
            m_k = 0; m_pre = 0; m_upd = 1;
         end else if (!en_a) begin
            m_pre = 0;
         end else if (tick_a) begin
            if (m_pre == 3) begin
               m_pre = 0; m_k = m_k + 1; m_upd = 1;
            end else begin
               m_pre = m_pre + 1;
            end
         end
      end
   end

   // Every-cycle comparison of the default instance against the model.
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("model duty ch%0d", i), chan(duty_a, i), exp_duty(i, m_k));
         check($sformatf("model dir ch%0d", i), int'(dir_a[i]), exp_dir(i, m_k));
      end
      check("model update", int'(upd_a), m_upd);
   end

   // Long-run statistics, gathered on update pulses.
   logic cnt_on = 1'b0;
   int   upd_cnt = 0, range_err = 0;
   int   hit_top [4] = '{0, 0, 0, 0};
   int   hit_bot [4] = '{0, 0, 0, 0};
   initial forever begin
      @(negedge clk);
      if (cnt_on) begin
         for (int i = 0; i < 4; i++)
            if (chan(duty_a, i) > 100) range_err++;
         if (upd_a) begin
            upd_cnt++;
            for (int i = 0; i < 4; i++) begin
               if (chan(duty_a, i) == 100) hit_top[i]++;
               if (chan(duty_a, i) == 0)   hit_bot[i]++;
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one tick; returns 1 time unit after the edge that sampled it.
   task automatic pulse_a();
      tick_a = 1'b1;
      cyc(1);
      tick_a = 1'b0;
   endtask

   int t3 [6] = '{100, 70, 40, 10, 0, 30};
   int d3 [6] = '{0, 0, 0, 0, 1, 1};
   int t0 [6] = '{30, 60, 90, 100, 70, 40};
   int d0 [6] = '{1, 1, 1, 0, 0, 0};

   initial begin
      // Reset applied with no clock edge.
      #1 rst = 1'b1;
      #1;
      check("reset duty", int'(duty_a), 32'h4B32_1900);
      check("reset dir", int'(dir_a), 4'hF);
      check("reset update", int'(upd_a), 0);
      @(posedge clk); #1;
      rst  = 1'b0;
      en_a = 1'b1;
      cyc(1);

      // Prescale: three ticks hold, the fourth steps.
      for (int n = 0; n < 3; n++) begin
         pulse_a();
         check("prescale hold ch0", chan(duty_a, 0), 0);
         check("prescale hold ch3", chan(duty_a, 3), 75);
      end
      pulse_a();
      check("prescale step ch0", chan(duty_a, 0), 1);
      check("prescale step ch3", chan(duty_a, 3), 76);
      check("prescale step update", int'(upd_a), 1);
      cyc(1);
      check("prescale update drop", int'(upd_a), 0);

      // Enable/hold: two ticks, disable for ten, then four more to step.
      pulse_a(); pulse_a();
      en_a = 1'b0;
      for (int n = 0; n < 10; n++) pulse_a();
      check("disabled ch0 frozen", chan(duty_a, 0), 1);
      en_a = 1'b1;
      for (int n = 0; n < 3; n++) pulse_a();
      check("reenable 3 ticks ch0", chan(duty_a, 0), 1);
      pulse_a();
      check("reenable 4th tick ch0", chan(duty_a, 0), 2);
      check("reenable 4th tick ch2", chan(duty_a, 2), 52);

      // Sync coincident with a step-completing tick.
      for (int n = 0; n < 3; n++) pulse_a();
      sync_a = 1'b1;
      tick_a = 1'b1;
      cyc(1);
      sync_a = 1'b0;
      tick_a = 1'b0;
      check("sync duty", int'(duty_a), 32'h4B32_1900);
      check("sync dir", int'(dir_a), 4'hF);
      check("sync update", int'(upd_a), 1);
      for (int n = 0; n < 3; n++) pulse_a();
      check("post-sync 3 ticks ch3", chan(duty_a, 3), 75);
      pulse_a();
      check("post-sync 4th tick ch3", chan(duty_a, 3), 76);

      // Asynchronous reset between edges while update is high.
      #2 rst = 1'b1;
      #1;
      check("async reset duty", int'(duty_a), 32'h4B32_1900);
      check("async reset update", int'(upd_a), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(1);

      // Turnaround on the STEP=30, STEP_DIV=1 instance with back-to-back ticks.
      sync_b = 1'b1;
      cyc(1);
      sync_b = 1'b0;
      check("b sync update", int'(upd_b), 1);
      check("b sync ch3", chan(duty_b, 3), 75);
      tick_b = 1'b1;
      for (int s = 0; s < 6; s++) begin
         cyc(1);
         check($sformatf("b step%0d ch3", s + 1), chan(duty_b, 3), t3[s]);
         check($sformatf("b step%0d dir3", s + 1), int'(dir_b[3]), d3[s]);
         check($sformatf("b step%0d ch0", s + 1), chan(duty_b, 0), t0[s]);
         check($sformatf("b step%0d dir0", s + 1), int'(dir_b[0]), d0[s]);
         check($sformatf("b step%0d update", s + 1), int'(upd_b), 1);
      end
      tick_b = 1'b0;
      cyc(1);
      check("b update drop", int'(upd_b), 0);

      // Long run: 800 ticks from the starting pattern.
      sync_a = 1'b1;
      cyc(1);
      sync_a = 1'b0;
      cyc(1);
      cnt_on = 1'b1;
      for (int n = 0; n < 800; n++) begin
         pulse_a();
         cyc(1);
      end
      cyc(1);
      cnt_on = 1'b0;
      check("long update count", upd_cnt, 200);
      check("long range", range_err, 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("long top hits ch%0d", i), hit_top[i], 1);
         check($sformatf("long bottom hits ch%0d", i), hit_bot[i], 1);
      end
      check("long end duty", int'(duty_a), 32'h4B32_1900);
      check("long end dir", int'(dir_a), 4'hF);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/pwm_fade_seq.md
# pwm_fade_seq

Upstream duty-cycle sequencer for the 4-channel LED PWM stage. It produces four duty values that ramp up and down in a triangle ("breathing") pattern, with a quarter-period phase offset between channels. It advances only on PWM period boundaries, so the downstream comparator never sees a duty change mid-period. The downstream PWM drives `period_tick_in` and consumes `duty_out`.

## Interface
- `PERIOD`, 100: downstream PWM counter maximum; the counter runs 0..PERIOD. Duty range is 0..PERIOD inclusive.
- `DUTY_W`, 8: width of each duty value. Requires PERIOD < 2^DUTY_W.
- `STEP`, 1: duty increment/decrement per step. Requires 1 ≤ STEP ≤ PERIOD.
- `STEP_DIV`, 4: number of PWM periods per step. Requires STEP_DIV ≥ 1.

Ports:
- `clk`  in  1: single clock, shared with the PWM stage.
- `rst_in`  in  1: asynchronous, active-high reset.
- `en_in`  in  1: sequencer enable.
- `sync_in`  in  1: one-cycle pulse; restarts the pattern from the reset state.
- `period_tick_in`  in  1: one-cycle pulse when the PWM counter wraps to 0.
- `duty_out`  out  4*DUTY_W: channel i at bits [i*DUTY_W +: DUTY_W]. Registered.
- `dir_out`  out  4: per channel, 1 = ramping up, 0 = ramping down. Registered.
- `update_out`  out  1: one-cycle pulse in the cycle `duty_out` takes new values.

## Operation
- Initial state, applied on reset and on sync:
  - duty_i = (i*PERIOD)/4, integer truncation. With PERIOD=100 this gives 0, 25, 50, 75.
  - dir_out = 4'b1111.
  - Prescaler = 0.
  - `update_out` = 0 on reset.
- Prescaler counts `period_tick_in` pulses while `en_in`=1. A step event occurs on a tick when prescaler == STEP_DIV-1; the prescaler then wraps to 0.
- On a step, each channel updates independently. Arithmetic is in DUTY_W+1 bits, so there is no wrap-around.
  - Up: if duty+STEP ≥ PERIOD, then duty=PERIOD and dir becomes 0. Otherwise duty += STEP.
  - Down: if duty ≤ STEP, then duty=0 and dir becomes 1. Otherwise duty -= STEP.
  - Endpoints PERIOD and 0 are each held for exactly one step. No double-hold.
- `en_in`=0:
  - Prescaler is cleared and held.
  - Duties and directions freeze.
  - No `update_out`.
  - Ticks are ignored.
- `sync_in`=1 (sampled regardless of `en_in`):
  - Loads the initial state.
  - Pulses `update_out` in the next cycle.
- Priority: `rst_in` > `sync_in` > step. A simultaneous sync and tick gives the sync result only; the tick is discarded.
- Reset mid-operation: all outputs return immediately (asynchronously) to their initial values. `update_out` = 0.

## Timing
- Step latency: the tick sampled at edge N produces new `duty_out`/`dir_out` and `update_out`=1 after edge N. `update_out` drops after edge N+1.
- Sync latency: same as a step, one edge.
- Back-to-back ticks with STEP_DIV=1 step every tick. Every step produces one `update_out` pulse.
- All outputs come straight from flops. There is no combinational path from inputs to outputs.
- Full triangle cycle per channel: 2*ceil(PERIOD/STEP) steps = 2*ceil(PERIOD/STEP)*STEP_DIV ticks.

## Test plan
- Reset: assert `rst_in` asynchronously between edges. `duty_out` = {75, 50, 25, 0} (ch3..ch0) immediately, `dir_out`=4'hF, `update_out`=0, with no clock edge required.
- Prescale (STEP_DIV=4, STEP=1, en=1): 3 ticks give no change. The 4th tick gives ch0=1, ch3=76, and exactly one `update_out` pulse one edge later.
- Turnaround (STEP=30, STEP_DIV=1): ch3 goes 75→100 (dir 0), then 70, 40, 10, then 0 (dir 1), then 30. ch0 goes 0→30→60→90→100.
- Enable/hold: deassert `en_in` after 2 of 4 ticks, apply 10 ticks, then re-enable. The first step occurs only after 4 further ticks, and duties are unchanged while disabled.
- Sync priority: from an arbitrary state, pulse `sync_in` coincident with a step-completing tick. The next cycle shows the initial values, `update_out`=1, and no step applied. The prescaler restarts at 0.
- Long run (defaults): 800 ticks. Check that every channel stays within 0..100, each endpoint is hit once per turnaround, the channel phase spacing of 25 is preserved modulo the reflection, and the `update_out` count is 200.
